apb_i2c_cmd_sequencer: RTL and testbench

//  APB master that sequences the APB-to-I2C bridge for a host command stream.

---
 rtl/apb_i2c_cmd_sequencer_if.sv | 32 +++
 rtl/apb_i2c_cmd_sequencer.sv | 150 +++++++++++++++
 tb/tb_apb_i2c_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_i2c_cmd_sequencer_if.sv
// Host command/response and APB bus bundle for the I2C bridge command sequencer.
// The master modport is the sequencer; the slave modport is the host plus the bridge.
interface apb_i2c_cmd_sequencer_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  CMD_VALID, CMD_OP, CMD_WDATA, PRDATA, PREADY, PSLVERR,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_OP, CMD_WDATA, PRDATA, PREADY, PSLVERR,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_i2c_cmd_sequencer.sv
// APB master turning host commands into one APB transfer each, with one response per command.
// Optional wait-state abort is enabled by defining APB_SEQ_TIMEOUT_EN.
module apb_i2c_cmd_sequencer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  apb_i2c_cmd_sequencer_if.master        bus,
  input  logic                           INT_RX,
  input  logic                           INT_TX,
  output logic                           BUSY
);

  localparam logic [1:0] OP_RX = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_RX = 3'd1,
    SETUP   = 3'd2,
    ACCESS  = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t     state;
  logic [1:0] op_q;

  // TX-empty is informational only
  logic unused_ok;
  assign unused_ok = INT_TX ^ TIMEOUT_CYCLES[0];

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             expired_c;
  assign expired_c = (wait_cnt == LAST_CNT);
`else
  assign bus.RSP_TIMEOUT = 1'b0;
`endif

  // Sequencer state and all registered outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      op_q          <= 2'b00;
      bus.CMD_READY <= 1'b1;
      BUSY          <= 1'b0;
      bus.PSELx     <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= 32'h0;
      bus.PWDATA    <= 32'h0;
      bus.RSP_VALID <= 1'b0;
      bus.RSP_RDATA <= 32'h0;
      bus.RSP_ERR   <= 1'b0;
`ifdef APB_SEQ_TIMEOUT_EN
      bus.RSP_TIMEOUT <= 1'b0;
      wait_cnt        <= '0;
`endif
    end else begin
      bus.RSP_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.CMD_VALID) begin
            op_q          <= bus.CMD_OP;
            bus.PADDR     <= BASE_ADDR + 32'({bus.CMD_OP, 2'b00});
            bus.PWRITE    <= (bus.CMD_OP != OP_RX);
            bus.PWDATA    <= bus.CMD_WDATA;
            bus.CMD_READY <= 1'b0;
            BUSY          <= 1'b1;
            if ((bus.CMD_OP == OP_RX) && INT_RX) begin
              state <= WAIT_RX;
`ifdef APB_SEQ_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              state     <= SETUP;
              bus.PSELx <= 1'b1;
            end
          end
        end
        WAIT_RX: begin
          if (!INT_RX) begin
            state     <= SETUP;
            bus.PSELx <= 1'b1;
          end
`ifdef APB_SEQ_TIMEOUT_EN
          else if (expired_c) begin
            state           <= RESP;
            bus.RSP_VALID   <= 1'b1;
            bus.RSP_RDATA   <= 32'h0;
            bus.RSP_ERR     <= 1'b1;
            bus.RSP_TIMEOUT <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
`ifdef APB_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          // PREADY coinciding with expiry completes normally
          if (bus.PREADY) begin
            state         <= RESP;
            bus.PSELx     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.RSP_VALID <= 1'b1;
            bus.RSP_RDATA <= (op_q == OP_RX) ? bus.PRDATA : 32'h0;
            bus.RSP_ERR   <= bus.PSLVERR;
`ifdef APB_SEQ_TIMEOUT_EN
            bus.RSP_TIMEOUT <= 1'b0;
`endif
          end
`ifdef APB_SEQ_TIMEOUT_EN
          else if (expired_c) begin
            state           <= RESP;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.RSP_VALID   <= 1'b1;
            bus.RSP_RDATA   <= 32'h0;
            bus.RSP_ERR     <= 1'b1;
            bus.RSP_TIMEOUT <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          state         <= IDLE;
          bus.CMD_READY <= 1'b1;
          BUSY          <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.PSELx     <= 1'b0;
          bus.PENABLE   <= 1'b0;
          bus.CMD_READY <= 1'b1;
          BUSY          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_i2c_cmd_sequencer.sv
// Directed bench for apb_i2c_cmd_sequencer: scoreboarded responses plus a small bridge register model.
// Define APB_SEQ_TIMEOUT_EN to also exercise the wait-state abort path.
module tb_apb_i2c_cmd_sequencer;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic int_rx;
  logic int_tx;
  logic busy;

  int n_vec = 0;
  int n_err = 0;
  rsp_t exp_q[$];
  logic [31:0] bridge_regs [4];

  apb_i2c_cmd_sequencer_if bus ();

  apb_i2c_cmd_sequencer #(
    .BASE_ADDR      (32'h0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus),
    .INT_RX  (int_rx),
    .INT_TX  (int_tx),
    .BUSY    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bridge register file: captures completed APB writes
  always @(posedge clk)
    if (bus.PSELx && bus.PENABLE && bus.PREADY && bus.PWRITE)
      bridge_regs[bus.PADDR[3:2]] <= bus.PWDATA;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one command at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [1:0] op, input logic [31:0] wd, input rsp_t exp, input logic expect_sel);
    chk1("cmd_ready_idle", bus.CMD_READY, 1'b1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = op;
    bus.CMD_WDATA = wd;
    exp_q.push_back(exp);
    tick();
    bus.CMD_VALID = 1'b0;
    chk1("busy_after_accept", busy, 1'b1);
    chk1("cmd_ready_busy", bus.CMD_READY, 1'b0);
    chk1("psel_after_accept", bus.PSELx, expect_sel);
    chk1("penable_setup", bus.PENABLE, 1'b0);
    chk("paddr", bus.PADDR, {28'h0, op, 2'b00});
    chk1("pwrite", bus.PWRITE, op != 2'b01);
    if (op != 2'b01) chk("pwdata", bus.PWDATA, wd);
  endtask

  // Wait (bounded) for the response pulse and compare against the scoreboard head
  task automatic wait_rsp(output int en_cycles, output int lat);
    rsp_t e;
    en_cycles = 0;
    lat = 0;
    while (!bus.RSP_VALID && lat < 64) begin
      if (bus.PENABLE) en_cycles++;
      tick();
      lat++;
    end
    chk1("rsp_valid_seen", bus.RSP_VALID, 1'b1);
    chk1("sb_has_entry", exp_q.size() != 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("rsp_rdata", bus.RSP_RDATA, e.rdata);
    chk1("rsp_err", bus.RSP_ERR, e.err);
    chk1("rsp_timeout", bus.RSP_TIMEOUT, e.tmo);
    chk1("psel_in_resp", bus.PSELx, 1'b0);
    chk1("penable_in_resp", bus.PENABLE, 1'b0);
    tick();
    chk1("rsp_single_pulse", bus.RSP_VALID, 1'b0);
    chk1("cmd_ready_back", bus.CMD_READY, 1'b1);
    chk1("busy_clear", busy, 1'b0);
    chk("rsp_rdata_hold", bus.RSP_RDATA, e.rdata);
  endtask

  initial begin
    int en;
    int lat;
    rst_n         = 1'b0;
    int_rx        = 1'b0;
    int_tx        = 1'b1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = 2'b00;
    bus.CMD_WDATA = 32'h0;
    bus.PRDATA    = 32'h0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;

    // Reset values
    repeat (2) tick();
    chk1("rst_cmd_ready", bus.CMD_READY, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_psel", bus.PSELx, 1'b0);
    chk1("rst_penable", bus.PENABLE, 1'b0);
    chk1("rst_rsp_valid", bus.RSP_VALID, 1'b0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk1("rst_rsp_timeout", bus.RSP_TIMEOUT, 1'b0);
    rst_n = 1'b1;
    tick();

    // TX write, minimum latency
    issue(2'b00, 32'hA5, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0}, 1'b1);
    wait_rsp(en, lat);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_enable_cycles", 32'(en), 32'd1);

    // CONFIG then TIMEOUT register writes
    issue(2'b10, 32'h1FFF, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0}, 1'b1);
    wait_rsp(en, lat);
    issue(2'b11, 32'h0123, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0}, 1'b1);
    wait_rsp(en, lat);
    chk("bridge_tx", bridge_regs[0], 32'hA5);
    chk("bridge_config", bridge_regs[2], 32'h1FFF);
    chk("bridge_timeout", bridge_regs[3], 32'h0123);

    // RX read held off while the RX FIFO is empty
    int_rx = 1'b1;
    bus.PRDATA = 32'h1234_5678;
    issue(2'b01, 32'hFFFF_FFFF, '{rdata: 32'hDEAD_BEEF, err: 1'b0, tmo: 1'b0}, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk1("rx_gate_psel", bus.PSELx, 1'b0);
      tick();
    end
    int_rx = 1'b0;
    bus.PRDATA = 32'hDEAD_BEEF;
    wait_rsp(en, lat);
    chk("t3_latency", 32'(lat), 32'd3);

    // Wait states then slave error
    bus.PREADY = 1'b0;
    issue(2'b00, 32'h5A5A, '{rdata: 32'h0, err: 1'b1, tmo: 1'b0}, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk1("ws_penable", bus.PENABLE, 1'b1);
      chk("ws_paddr_stable", bus.PADDR, 32'h0);
      chk("ws_pwdata_stable", bus.PWDATA, 32'h5A5A);
      if (i == 5) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
      end
      tick();
    end
    bus.PSLVERR = 1'b0;
    wait_rsp(en, lat);

`ifdef APB_SEQ_TIMEOUT_EN
    // Stuck PREADY aborts after 16 ACCESS cycles; sequencer recovers
    bus.PREADY = 1'b0;
    issue(2'b00, 32'h1, '{rdata: 32'h0, err: 1'b1, tmo: 1'b1}, 1'b1);
    wait_rsp(en, lat);
    chk("t5_access_cycles", 32'(en), 32'd16);
    bus.PREADY = 1'b1;
    issue(2'b10, 32'h2, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0}, 1'b1);
    wait_rsp(en, lat);
`endif

    // Reset in the middle of ACCESS: bus drops immediately, no response
    bus.PREADY = 1'b0;
    issue(2'b00, 32'h77, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0}, 1'b1);
    void'(exp_q.pop_back());
    tick();
    chk1("t6_in_access", bus.PENABLE, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_psel_async", bus.PSELx, 1'b0);
    chk1("t6_penable_async", bus.PENABLE, 1'b0);
    @(posedge clk);
    #1;
    chk1("t6_no_rsp", bus.RSP_VALID, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.PREADY = 1'b1;
    tick();
    chk1("t6_ready_after", bus.CMD_READY, 1'b1);
    chk1("t6_busy_after", busy, 1'b0);
    chk1("t6_rsp_after", bus.RSP_VALID, 1'b0);
    issue(2'b10, 32'h3, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0}, 1'b1);
    wait_rsp(en, lat);
    chk("bridge_config_after_reset", bridge_regs[2], 32'h3);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
